// File: rtl/mpu_pkg.sv
// Shared definitions for the 5x5 signed-int8 matrix pipeline: geometry, loader
// state encoding and the element slot-offset helper.
package mpu_pkg;

  localparam int N        = 5;
  localparam int ELEM_W   = 8;
  localparam int MAT_BITS = ELEM_W * N * N;
  localparam int IDX_W    = $clog2(N * N);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_t;

  // Bit offset of element (r,c) inside a flattened operand bus.
  function automatic int at(input int r, input int c);
    return ELEM_W * (N * r + c);
  endfunction

endpackage

// File: rtl/mpu_matrix_loader.sv
// Byte-stream feeder for the matrix multiplier: packs A then B from a valid/ready
// stream into two flattened buses and holds them with out_valid until consumed.
module mpu_matrix_loader
  import mpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:MAT_BITS-1] matrix_a,
  output logic [0:MAT_BITS-1] matrix_b,
  output logic                err
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             err_nxt;
  logic             ready_en;
  logic             xfer;
  logic             last_slot;
  logic             wr_a, wr_b;

  // ready_en keeps in_ready low while rst is held and for the release cycle.
  assign in_ready  = ready_en && (state != FULL);
  assign out_valid = (state == FULL);
  assign xfer      = in_valid && in_ready;
  assign last_slot = (idx == IDX_W'(N * N - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    if (flush) begin
      state_nxt = LOAD_A;
      idx_nxt   = '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            if (in_last) begin
              err_nxt = 1'b1;
              idx_nxt = '0;
            end else begin
              wr_a = 1'b1;
              if (last_slot) begin
                state_nxt = LOAD_B;
                idx_nxt   = '0;
              end else begin
                idx_nxt = idx + 1'b1;
              end
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            // in_last must be set on exactly the final element of B.
            if (in_last != last_slot) begin
              err_nxt   = 1'b1;
              state_nxt = LOAD_A;
              idx_nxt   = '0;
            end else begin
              wr_b = 1'b1;
              if (last_slot) begin
                state_nxt = FULL;
                idx_nxt   = '0;
              end else begin
                idx_nxt = idx + 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_nxt = LOAD_A;
            idx_nxt   = '0;
          end
        end
        default: begin
          state_nxt = LOAD_A;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= LOAD_A;
      idx      <= '0;
      err      <= 1'b0;
      ready_en <= 1'b0;
      // NOTE: the operand registers are cleared on reset because downstream
      // relies on all-zero buses after reset, not only on out_valid.
      matrix_a <= '0;
      matrix_b <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      err      <= err_nxt;
      ready_en <= 1'b1;
      if (wr_a) matrix_a[ELEM_W * int'(idx) +: ELEM_W] <= in_data;
      if (wr_b) matrix_b[ELEM_W * int'(idx) +: ELEM_W] <= in_data;
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: expected operand frames are queued as
// stimulus is built and compared when the loader presents out_valid.
module tb_mpu_matrix_loader;
  import mpu_pkg::*;

  typedef struct packed {
    logic [0:MAT_BITS-1] a;
    logic [0:MAT_BITS-1] b;
  } frame_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [ELEM_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [0:MAT_BITS-1] matrix_a;
  logic [0:MAT_BITS-1] matrix_b;
  logic                err;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  frame_t      sb[$];
  frame_t      cur;
  logic [7:0]  fr[2*N*N];

  mpu_matrix_loader dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .matrix_a  (matrix_a),
    .matrix_b  (matrix_b),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [MAT_BITS-1:0] obs,
                     input logic [MAT_BITS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected buses are built from the row/column mapping of the stream.
  task automatic push_expected();
    frame_t f;
    f = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        f.a[at(r, c) +: ELEM_W] = fr[N*r + c];
        f.b[at(r, c) +: ELEM_W] = fr[N*N + N*r + c];
      end
    sb.push_back(f);
  endtask

  task automatic send_elem(input logic [7:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int count, input int last_at, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (k == count - 1) chk("ov_before_final", out_valid, 0);
      send_elem(fr[k], k == last_at, gaps ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic wait_and_pop(input string tag);
    for (int t = 0; t < 200 && !out_valid; t++) @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      cur = sb.pop_front();
      chk({tag, "_matrix_a"}, matrix_a, cur.a);
      chk({tag, "_matrix_b"}, matrix_b, cur.b);
    end
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_in_ready"}, in_ready, 1);
    chk({tag, "_rel_out_valid"}, out_valid, 0);
  endtask

  initial begin
    int t0;
    logic [0:MAT_BITS-1] all_80;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    all_80 = {(N*N){8'h80}};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_matrix_a", matrix_a, '0);
    chk("rst_matrix_b", matrix_b, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Scenario 1: A = 1..25, B = identity, back-to-back
    for (int k = 0; k < N*N; k++) fr[k] = 8'(k + 1);
    for (int k = 0; k < N*N; k++) fr[N*N + k] = (k % (N + 1) == 0) ? 8'd1 : 8'd0;
    push_expected();
    t0 = cyc;
    send_frame(2*N*N, 2*N*N - 1, 0);
    chk("frame1_cycles", cyc - t0, 2*N*N);
    chk("frame1_latency", out_valid, 1);
    wait_and_pop("frame1");

    // Scenario 2: downstream stall with upstream pushing
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_matrix_a", matrix_a, cur.a);
      chk("stall_matrix_b", matrix_b, cur.b);
    end
    in_valid = 1'b0;
    release_frame("stall");

    // Scenario 3: early in_last on element 30, then all -128
    for (int k = 0; k < 2*N*N; k++) fr[k] = 8'(3 * k + 7);
    send_frame(31, 30, 0);
    chk("early_last_err", err, 1);
    chk("early_last_ov", out_valid, 0);
    @(negedge clk);
    chk("early_last_err_pulse", err, 0);
    chk("early_last_ov2", out_valid, 0);
    for (int k = 0; k < 2*N*N; k++) fr[k] = 8'h80;
    push_expected();
    send_frame(2*N*N, 2*N*N - 1, 0);
    wait_and_pop("neg128");
    chk("neg128_a_const", matrix_a, all_80);
    chk("neg128_b_const", matrix_b, all_80);
    release_frame("neg128");

    // Scenario 4: missing in_last on element 49, then gapped good frame
    for (int k = 0; k < 2*N*N; k++) fr[k] = 8'(k ^ 8'h3c);
    send_frame(2*N*N, -1, 0);
    chk("no_last_err", err, 1);
    chk("no_last_ov", out_valid, 0);
    @(negedge clk);
    chk("no_last_err_pulse", err, 0);
    chk("no_last_ov2", out_valid, 0);
    for (int k = 0; k < N*N; k++) fr[k] = 8'(k + 1);
    for (int k = 0; k < N*N; k++) fr[N*N + k] = (k % (N + 1) == 0) ? 8'd1 : 8'd0;
    push_expected();
    send_frame(2*N*N, 2*N*N - 1, 1);
    wait_and_pop("gapped");
    release_frame("gapped");

    // Scenario 5a: flush at element 40 with a concurrent transfer
    for (int k = 0; k < 2*N*N; k++) fr[k] = 8'(k ^ 8'ha5);
    send_frame(40, -1, 0);
    in_valid = 1'b1;
    in_data  = fr[40];
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_mid_ov", out_valid, 0);
    chk("flush_mid_err", err, 0);
    chk("flush_mid_in_ready", in_ready, 1);
    push_expected();
    send_frame(2*N*N, 2*N*N - 1, 0);
    wait_and_pop("after_flush");

    // Scenario 5b: flush while FULL
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_full_ov", out_valid, 0);
    chk("flush_full_err", err, 0);
    chk("flush_full_in_ready", in_ready, 1);
    chk("flush_full_keep_a", matrix_a, cur.a);

    // Scenario 5c: asynchronous reset at element 12
    for (int k = 0; k < 2*N*N; k++) fr[k] = 8'(200 - k);
    send_frame(12, -1, 0);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_err", err, 0);
    chk("arst_matrix_a", matrix_a, '0);
    chk("arst_matrix_b", matrix_b, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_release_in_ready", in_ready, 1);
    push_expected();
    send_frame(2*N*N, 2*N*N - 1, 1);
    wait_and_pop("after_arst");
    release_frame("after_arst");
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
